// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] PC_INC    = 16'd2;

  typedef enum logic [2:0] {
    StReq    = 3'd0,
    StWait   = 3'd1,
    StHold   = 3'd2,
    StSquash = 3'd3,
    StHalted = 3'd4
  } state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_stage_if;

  logic [15:0] addr;
  logic        rd;
  logic        stall;
  logic        done;
  logic [15:0] data;

  modport master (output addr, output rd, input stall, input done, input data);
  modport slave  (input addr, input rd, output stall, output done, output data);

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module fetch_stage_ifid_reg #(
  parameter logic [15:0] BubbleInstr = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        bubble_fs_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o,
  output logic        valid_o,
  output logic        fetch_stall_o
);

  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        fs_q, fs_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
      fs_d    = 1'b0;
    end else if (bubble_i) begin
      // PC field is left alone on a bubble; only valid instructions carry a meaningful PC.
      instr_d = BubbleInstr;
      valid_d = 1'b0;
      fs_d    = bubble_fs_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= BubbleInstr;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign valid_o       = valid_q;
  assign fetch_stall_o = fs_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a multi-cycle imem, feeds IF/ID,
// and handles redirect, hazard stall and halt from decode.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [15:0]          redirectPC,
  input  logic                 halt,
  fetch_stage_if.master        imem,
  output logic [15:0]          instr,
  output logic [15:0]          PC,
  output logic                 valid,
  output logic                 fetch_stall,
  output logic                 err
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;
  logic        err_q, err_d;
  logic        out_q, out_d;      // a response is still owed to us while halted
  logic        first_q;           // first cycle after reset: ignore stray responses

  logic        rd;
  logic        accept;
  logic        deliver;
  logic [15:0] pc_inc;
  logic        ld, bub, bub_fs;
  logic [15:0] ld_instr;

  assign pc_inc = pc_q + PC_INC;
  assign rd     = (state_q == StReq) && !rst && !halt;
  assign accept = rd && !imem.stall;

  assign imem.addr = pc_q;
  assign imem.rd   = rd;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    out_d    = out_q;
    ld       = 1'b0;
    bub      = 1'b0;
    bub_fs   = 1'b0;
    ld_instr = imem.data;
    deliver  = 1'b0;

    if (halt || state_q == StHalted) begin
      state_d = StHalted;
      bub     = 1'b1;
      if (state_q != StHalted) begin
        out_d = (state_q == StWait || state_q == StSquash) && !imem.done;
      end else if (imem.done) begin
        out_d = 1'b0;
      end
    end else if (redirect && !stall) begin
      pc_d   = redirectPC & 16'hFFFE;
      bub    = 1'b1;
      hold_d = NOP_INSTR;
      if ((state_q == StWait || state_q == StSquash || accept) && !imem.done) begin
        state_d = StSquash;
      end else begin
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (accept) begin
            if (imem.done) deliver = 1'b1;
            else           state_d = StWait;
          end
        end
        StWait: begin
          if (imem.done) deliver = 1'b1;
        end
        StHold: begin
          if (!stall) begin
            ld       = 1'b1;
            ld_instr = hold_q;
            pc_d     = pc_inc;
            state_d  = StReq;
          end
        end
        StSquash: begin
          if (imem.done) state_d = StReq;
        end
        default: state_d = StReq;
      endcase

      if (deliver) begin
        if (stall) begin
          hold_d  = imem.data;
          state_d = StHold;
        end else begin
          ld      = 1'b1;
          pc_d    = pc_inc;
          state_d = StReq;
        end
      end else if (!stall && !ld) begin
        bub    = 1'b1;
        bub_fs = 1'b1;
      end
    end

    err_d = err_q | (imem.done && !first_q &&
                     ((state_q == StHold) ||
                      (state_q == StReq && !accept) ||
                      (state_q == StHalted && !out_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      out_q   <= out_d;
      first_q <= 1'b0;
    end
  end

  fetch_stage_ifid_reg #(
    .BubbleInstr (NOP_INSTR)
  ) u_ifid (
    .clk           (clk),
    .rst           (rst),
    .load_i        (ld),
    .bubble_i      (bub),
    .bubble_fs_i   (bub_fs),
    .instr_i       (ld_instr),
    .pc_i          (pc_inc),
    .instr_o       (instr),
    .pc_o          (PC),
    .valid_o       (valid),
    .fetch_stall_o (fetch_stall)
  );

  assign err = err_q;

endmodule
